// File: rtl/uart_tx_framer_if.sv
// Payload handshake between a word producer and the UART transmit framer.
interface uart_tx_framer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS payload, optional parity, STOP_BITS stop bits.
// Optional parity bit is compiled in with macro UART_TX_FRAMER_PARITY_EN.
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    uart_tx_framer_if.slave   bus,
    output logic              tx,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_FRAMER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 ||
        STOP_BITS < 1 || STOP_BITS > 2 || MSB_FIRST < 0 || MSB_FIRST > 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_framer: parameter out of legal range");
    end

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, sh_nxt;
    logic                 tx_q, tx_d;
    logic                 tick, take;
`ifdef UART_TX_FRAMER_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Bit that goes on the line next from a given shift-register image.
    function automatic logic lead_bit(input logic [DATA_BITS-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_BITS-1] : v[0];
    endfunction

    assign tick      = (cnt_q == '0);
    assign bus.ready = (state_q == S_IDLE) ||
                       (state_q == S_STOP && tick && stop_q == STOP_LAST);
    assign take      = bus.valid && bus.ready;
    assign tx        = tx_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
`ifdef UART_TX_FRAMER_PARITY_EN
        par_d   = par_q;
`endif
        sh_nxt  = (MSB_FIRST != 0) ? {sh_q[DATA_BITS-2:0], 1'b0} : {1'b0, sh_q[DATA_BITS-1:1]};
        // Acceptance only happens in IDLE or the last stop cycle, so it overrides the bit timing.
        if (take) begin
            state_d = S_START;
            tx_d    = 1'b0;
            cnt_d   = CNT_LOAD;
            idx_d   = IDX_TOP;
            stop_d  = 1'b0;
            sh_d    = bus.data;
`ifdef UART_TX_FRAMER_PARITY_EN
            par_d   = (^bus.data) ^ 1'(PARITY_ODD);
`endif
        end else if (state_q != S_IDLE) begin
            if (!tick) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = CNT_LOAD;
                case (state_q)
                    S_START: begin
                        state_d = S_DATA;
                        tx_d    = lead_bit(sh_q);
                    end
                    S_DATA: begin
                        if (idx_q == '0) begin
`ifdef UART_TX_FRAMER_PARITY_EN
                            state_d = S_PARITY;
                            tx_d    = par_q;
`else
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
`endif
                        end else begin
                            idx_d = idx_q - IW'(1);
                            sh_d  = sh_nxt;
                            tx_d  = lead_bit(sh_nxt);
                        end
                    end
`ifdef UART_TX_FRAMER_PARITY_EN
                    S_PARITY: begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                        stop_d  = 1'b0;
                    end
`endif
                    S_STOP: begin
                        if (stop_q == STOP_LAST) begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            stop_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_FRAMER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
`ifdef UART_TX_FRAMER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomized self-checking bench for uart_tx_framer against a frame-level reference model.
module tb_uart_tx_framer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef UART_TX_FRAMER_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    uart_tx_framer_if #(.DATA_BITS(8)) b0 ();
    uart_tx_framer_if #(.DATA_BITS(8)) b1 ();
    uart_tx_framer_if #(.DATA_BITS(8)) b2 ();
    logic tx0, tx1, tx2, busy0, busy1, busy2;

    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0))
        dut0 (.CLK(clk), .RESET(rst), .bus(b0), .tx(tx0), .busy(busy0));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(1), .STOP_BITS(2), .MSB_FIRST(1), .PARITY_ODD(0))
        dut1 (.CLK(clk), .RESET(rst), .bus(b1), .tx(tx1), .busy(busy1));
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(3), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(1))
        dut2 (.CLK(clk), .RESET(rst), .bus(b2), .tx(tx2), .busy(busy2));

    int vectors     = 0;
    int miscompares = 0;
    bit exp_tx[$];
    bit exp_rdy[$];
    logic [7:0] words_q[$];

    function automatic int cpb_of(input int id);
        case (id)
            0: return 4;
            1: return 1;
            default: return 3;
        endcase
    endfunction
    function automatic int stops_of(input int id);
        return (id == 1) ? 2 : 1;
    endfunction
    function automatic bit msb_of(input int id);
        return (id != 2);
    endfunction
    function automatic bit odd_of(input int id);
        return (id == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for every cycle of one frame; ready is due in its last cycle only.
    task automatic model_frame(input int id, input logic [7:0] d);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(msb_of(id) ? d[7-i] : d[i]);
        if (PEN != 0) bits.push_back((^d) ^ odd_of(id));
        for (int s = 0; s < stops_of(id); s++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int c = 0; c < cpb_of(id); c++) begin
                exp_tx.push_back(bits[i]);
                exp_rdy.push_back(1'b0);
            end
        end
        exp_rdy[exp_rdy.size()-1] = 1'b1;
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] d);
        case (id)
            0: begin b0.valid = v; b0.data = d; end
            1: begin b1.valid = v; b1.data = d; end
            default: begin b2.valid = v; b2.data = d; end
        endcase
    endtask

    function automatic logic [2:0] obs(input int id);
        case (id)
            0: return {tx0, busy0, b0.ready};
            1: return {tx1, busy1, b1.ready};
            default: return {tx2, busy2, b2.ready};
        endcase
    endfunction

    // Call at a falling edge with the DUT idle; sends words_q with valid held across frames.
    task automatic run_stream(input int id);
        int wi = 0;
        logic [2:0] o;
        exp_tx.delete();
        exp_rdy.delete();
        foreach (words_q[i]) model_frame(id, words_q[i]);
        drive(id, 1'b1, words_q[0]);
        for (int k = 0; k < exp_tx.size(); k++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs(id);
            chk($sformatf("dut%0d tx cyc%0d", id, k), 32'(o[2]), 32'(exp_tx[k]));
            chk($sformatf("dut%0d busy cyc%0d", id, k), 32'(o[1]), 32'd1);
            chk($sformatf("dut%0d ready cyc%0d", id, k), 32'(o[0]), 32'(exp_rdy[k]));
            if (exp_rdy[k]) begin
                wi++;
                if (wi < words_q.size()) drive(id, 1'b1, words_q[wi]);
                else drive(id, 1'b0, 8'($urandom));
            end else begin
                drive(id, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            o = obs(id);
            chk($sformatf("dut%0d idle tx", id), 32'(o[2]), 32'd1);
            chk($sformatf("dut%0d idle busy", id), 32'(o[1]), 32'd0);
            chk($sformatf("dut%0d idle ready", id), 32'(o[0]), 32'd1);
        end
    endtask

    initial begin
        logic [2:0] o;
        rst = 1'b0;
        for (int id = 0; id < 3; id++) drive(id, 1'b0, 8'h00);
        #1 rst = 1'b1;
        #2;
        for (int id = 0; id < 3; id++) begin
            o = obs(id);
            chk($sformatf("dut%0d reset tx", id), 32'(o[2]), 32'd1);
            chk($sformatf("dut%0d reset busy", id), 32'(o[1]), 32'd0);
            chk($sformatf("dut%0d reset ready", id), 32'(o[0]), 32'd1);
        end
        @(negedge clk);
        rst = 1'b0;

        words_q = '{8'hA5};       run_stream(0);
        words_q = '{8'h11, 8'h22}; run_stream(0);
        words_q = '{8'h07};       run_stream(0);
        words_q = '{8'h01};       run_stream(2);
        words_q = '{8'h07};       run_stream(2);
        words_q = '{8'h80};       run_stream(1);
        words_q = '{8'h3C, 8'hC3, 8'h00}; run_stream(1);

        for (int n = 0; n < 15; n++) begin
            words_q.delete();
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) words_q.push_back(8'($urandom));
            run_stream(n % 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Abort a frame of zeros during data bit 3, then check a clean frame follows.
        drive(0, 1'b1, 8'h00);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h00);
        repeat (17) @(posedge clk);
        #2;
        chk("abort pre tx", 32'(tx0), 32'd0);
        chk("abort pre busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort tx", 32'(tx0), 32'd1);
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort ready", 32'(b0.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        words_q = '{8'hFF}; run_stream(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, payload bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, CLK cycles per serial bit, legal range 1..65535.
REQ-003 The block SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 The block SHALL have parameter MSB_FIRST, default 1, where 1 sends data[DATA_BITS-1] first and 0 sends data[0] first.
REQ-005 The block SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd; it is used only when parity is compiled in.
REQ-006 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port RESET, input, 1 bit, an asynchronous active-high reset.
REQ-008 The block SHALL have port data, input, DATA_BITS bits, the payload word.
REQ-009 The block SHALL have port valid, input, 1 bit, meaning data is offered.
REQ-010 The block SHALL have port ready, output, 1 bit, meaning the block accepts data this cycle.
REQ-011 The block SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a frame is on the line.

Function
REQ-013 A transfer SHALL occur on a rising CLK edge where valid && ready; data SHALL be captured into an internal shift register at that edge.
REQ-014 The FSM SHALL use states IDLE, START, DATA, PARITY and STOP; PARITY exists only when parity is compiled in.
- IDLE -> START on a transfer.
- START -> DATA.
- DATA -> PARITY, or DATA -> STOP when parity is absent, after DATA_BITS bits.
- PARITY -> STOP.
- STOP -> IDLE, or STOP -> START on a back-to-back transfer.
REQ-015 tx SHALL be registered, with no combinational path from valid or data to tx.
REQ-016 The start bit (0) SHALL appear on tx in the first cycle after the accepting edge.
REQ-017 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, timed by a down-counter of width clog2(CLKS_PER_BIT+1) that reloads at each bit boundary.
REQ-018 Bit order SHALL follow MSB_FIRST, and the payload bit index SHALL count DATA_BITS-1 down to 0 without wrap-around.
REQ-019 The stop phase SHALL drive tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 Frame length SHALL be (1+DATA_BITS+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 when parity is compiled in and P=0 otherwise.
REQ-021 ready SHALL be high in IDLE and in the final cycle of the last stop bit, and low otherwise.
REQ-022 A transfer in the final stop cycle SHALL start the next frame's start bit in the following cycle, with zero idle gap.
REQ-023 busy SHALL be high from the cycle after acceptance through the final stop cycle inclusive.
REQ-024 Changes to data or valid while ready is low SHALL have no effect on the frame in flight.
REQ-025 With CLKS_PER_BIT=1, every bit SHALL last one cycle and all rules above SHALL still hold.

Reset
REQ-026 Asserting RESET SHALL immediately force state=IDLE, tx=1, ready=1, busy=0, the shift register to 0 and the counters to 0.
REQ-027 A reset asserted mid-frame SHALL abort the frame, and tx SHALL return high asynchronously with no partial-bit completion.
REQ-028 After RESET deasserts, the first rising edge SHALL be able to accept a transfer.

Configuration
REQ-029 When macro UART_TX_FRAMER_PARITY_EN is defined, a parity bit SHALL be sent for CLKS_PER_BIT cycles between the last data bit and the stop bits; its value SHALL be the XOR of the data bits when PARITY_ODD=0 and its inverse when PARITY_ODD=1.
REQ-030 When UART_TX_FRAMER_PARITY_EN is undefined, the PARITY state, parity logic and PARITY_ODD usage SHALL be absent, and STOP SHALL follow DATA directly.

Verification
REQ-031 With defaults, no parity, and data=8'hA5 accepted at edge T: tx SHALL be 0 for cycles T+1..T+4, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; ready SHALL be high again at cycle T+40.
REQ-032 With MSB_FIRST=0 and data=8'h01: the first data bit SHALL be 1 and the remaining 7 data bits SHALL be 0.
REQ-033 With parity compiled in, PARITY_ODD=0 and data=8'h07: the parity bit SHALL be 1 and the frame SHALL last 44 cycles; with PARITY_ODD=1 the parity bit SHALL be 0.
REQ-034 With valid held high and data 8'h11 followed by 8'h22: the second start bit SHALL immediately follow the first frame's stop bit with no idle cycle, and ready SHALL be high for exactly 1 cycle per frame.
REQ-035 With RESET pulsed during data bit 3 of a frame: tx SHALL be 1 and busy SHALL be 0 in the same cycle, and a new transfer of 8'hFF after release SHALL produce a clean full frame.
REQ-036 With CLKS_PER_BIT=1, STOP_BITS=2 and data=8'h80: the frame SHALL be 11 cycles long, with tx sequence 0,1,0,0,0,0,0,0,0,1,1.
